// File: rtl/if_fetch_unit.sv
// if_fetch_unit: instruction-fetch stage feeding the IF/ID register.
// Holds the PC, addresses instruction memory, predicts the next PC for
// RV32 B-type branches and applies hazard stalls and EX-stage redirects.
//
// Optional feature macro: BHT_EN
//   defined   -> table of 2**BHT_IDX_W 2-bit saturating counters predicts branches
//   undefined -> no table; always predicts not-taken (pc+4), upd_* ignored
//
// Ports:
//   clk_i, rst_i          clock (rising edge), async active-low reset
//   stall_i               hold PC
//   redirect_i            load redirect_pc_i, flush IF/ID (beats stall_i)
//   redirect_pc_i         corrected PC
//   upd_valid_i/_pc_i/_taken_i  resolved-branch counter update
//   imem_addr_o           instruction-memory address (= pc)
//   imem_inst_i           instruction word, combinational read of imem_addr_o
//   pc_o, inst_o          current PC / instruction to IF/ID
//   pcnxt_o               predicted next PC
//   pred_taken_o          prediction flag for current instruction
//   flush_o               IF/ID flush (= redirect_i)
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BHT_IDX_W = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_taken_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_inst_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic [31:0] pcnxt_o,
  output logic        pred_taken_o,
  output logic        flush_o
);

  localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
  localparam logic [31:0] PC_STEP    = 32'd4;

  logic [31:0] pc_q, pc_d;
  logic        is_br;
  logic [31:0] br_imm;
  logic        pred_taken;
  logic [31:0] pcnxt;

  // B-type decode of the fetched word
  assign is_br  = (imem_inst_i[6:0] == OPC_BRANCH);
  assign br_imm = {{19{imem_inst_i[31]}}, imem_inst_i[31], imem_inst_i[7],
                   imem_inst_i[30:25], imem_inst_i[11:8], 1'b0};

`ifdef BHT_EN
  localparam int unsigned BHT_N = 32'(1) << BHT_IDX_W;

  logic [1:0]           bht_q [BHT_N];
  logic [1:0]           bht_d [BHT_N];
  logic [BHT_IDX_W-1:0] lkp_idx;
  logic [BHT_IDX_W-1:0] upd_idx;
  logic                 unused_upd;

  assign lkp_idx    = pc_q[BHT_IDX_W+1:2];
  assign upd_idx    = upd_pc_i[BHT_IDX_W+1:2];
  assign unused_upd = ^{upd_pc_i[31:BHT_IDX_W+2], upd_pc_i[1:0]};

  // Lookup reads the registered table, so a same-cycle update is not bypassed
  assign pred_taken = is_br & bht_q[lkp_idx][1];

  // Saturating counter update for the resolved branch
  always_comb begin
    bht_d = bht_q;
    if (upd_valid_i) begin
      if (upd_taken_i) begin
        if (bht_q[upd_idx] != 2'b11) bht_d[upd_idx] = bht_q[upd_idx] + 2'd1;
      end else begin
        if (bht_q[upd_idx] != 2'b00) bht_d[upd_idx] = bht_q[upd_idx] - 2'd1;
      end
    end
  end

  // Counter table; reset to weakly not-taken
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < int'(BHT_N); i++) bht_q[i] <= 2'b01;
    end else begin
      bht_q <= bht_d;
    end
  end
`else
  logic unused_bht;

  assign pred_taken = 1'b0;
  assign unused_bht = ^{upd_valid_i, upd_pc_i, upd_taken_i, is_br};
`endif

  assign pcnxt = pred_taken ? (pc_q + br_imm) : (pc_q + PC_STEP);

  // Next PC: redirect beats stall beats sequential/predicted flow
  always_comb begin
    pc_d = pc_q;
    if (redirect_i) begin
      pc_d = redirect_pc_i;
    end else if (!stall_i) begin
      pc_d = pcnxt;
    end
  end

  // PC register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign imem_addr_o  = pc_q;
  assign pc_o         = pc_q;
  assign inst_o       = imem_inst_i;
  assign pcnxt_o      = pcnxt;
  assign pred_taken_o = pred_taken;
  assign flush_o      = redirect_i;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed stimulus, a behavioural reference model
// and a per-cycle compare process, plus literal checks for key scenarios.
module tb_if_fetch_unit;

`ifdef BHT_EN
  localparam bit BHT_ON = 1'b1;
`else
  localparam bit BHT_ON = 1'b0;
`endif
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] BEQ_M4   = 32'hFE00_0EE3;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        upd_valid_i = 1'b0;
  logic [31:0] upd_pc_i = '0;
  logic        upd_taken_i = 1'b0;
  logic [31:0] imem_addr_o;
  logic [31:0] imem_inst_i;
  logic [31:0] pc_o, inst_o, pcnxt_o;
  logic        pred_taken_o, flush_o;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  logic [31:0] mem [1024];

  always #5 clk_i = ~clk_i;

  assign imem_inst_i = mem[imem_addr_o[11:2]];

  if_fetch_unit #(.RESET_PC(RESET_PC), .BHT_IDX_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
    .imem_addr_o(imem_addr_o), .imem_inst_i(imem_inst_i),
    .pc_o(pc_o), .inst_o(inst_o), .pcnxt_o(pcnxt_o),
    .pred_taken_o(pred_taken_o), .flush_o(flush_o)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_pc;
  logic [31:0] m_nxt;
  int          ctr [16];

  function automatic logic [31:0] m_inst();
    return mem[(m_pc / 4) % 1024];
  endfunction

  function automatic bit m_is_br(input logic [31:0] w);
    return (w % 128) == 32'h63;
  endfunction

  // Branch offset: bit 12 weighs -4096, the rest are positive field weights
  function automatic logic [31:0] m_imm(input logic [31:0] w);
    int v;
    v = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    return 32'(v);
  endfunction

  function automatic bit m_pred();
    if (!BHT_ON) return 1'b0;
    return m_is_br(m_inst()) && (ctr[(m_pc / 4) % 16] >= 2);
  endfunction

  function automatic logic [31:0] m_pcnxt();
    return m_pred() ? m_pc + m_imm(m_inst()) : m_pc + 32'd4;
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_pc = RESET_PC;
      for (int i = 0; i < 16; i++) ctr[i] = 1;
    end else begin
      m_nxt = m_pcnxt();
      if (BHT_ON && upd_valid_i) begin
        int k;
        k = int'((upd_pc_i / 4) % 16);
        if (upd_taken_i) ctr[k] = (ctr[k] < 3) ? ctr[k] + 1 : 3;
        else             ctr[k] = (ctr[k] > 0) ? ctr[k] - 1 : 0;
      end
      if (redirect_i)    m_pc = redirect_pc_i;
      else if (!stall_i) m_pc = m_nxt;
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("m_addr",  imem_addr_o, m_pc);
      chk("m_pc",    pc_o,        m_pc);
      chk("m_inst",  inst_o,      m_inst());
      chk("m_pcnxt", pcnxt_o,     m_pcnxt());
      chk("m_pred",  32'(pred_taken_o), 32'(m_pred()));
      chk("m_flush", 32'(flush_o),      32'(redirect_i));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk_i);
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input int n);
    for (int i = 0; i < n; i++) begin
      upd_valid_i = 1'b1;
      upd_pc_i    = pc;
      upd_taken_i = taken;
      tick();
    end
    upd_valid_i = 1'b0;
  endtask

  task automatic jump(input logic [31:0] pc, input logic hold);
    redirect_i    = 1'b1;
    redirect_pc_i = pc;
    tick();
    redirect_i    = 1'b0;
    stall_i       = hold;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = NOP;
    mem[32'h40 / 4] = BEQ_M4;
    mem[32'h4C / 4] = BEQ_M4;

    // 1: reset, then sequential NOP fetch
    #2 rst_i = 1'b0;
    chk_en = 1'b1;
    repeat (2) tick();
    rst_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      at_neg();
      chk("t1_pc", pc_o, 32'(4 * k));
      chk("t1_pred", 32'(pred_taken_o), 32'd0);
      chk("t1_flush", 32'(flush_o), 32'd0);
    end
    tick();

    // 2: branch at 0x40, counter trained by two taken updates
    redirect_i = 1'b1;
    redirect_pc_i = 32'h40;
    at_neg();
    chk("t2_flush", 32'(flush_o), 32'd1);
    tick();
    redirect_i = 1'b0;
    stall_i = 1'b1;
    at_neg();
    chk("t2_pc", pc_o, 32'h40);
    chk("t2_nxt0", pcnxt_o, 32'h44);
    chk("t2_pred0", 32'(pred_taken_o), 32'd0);
    tick();
    upd(32'h40, 1'b1, 2);
    at_neg();
    chk("t2_nxt2", pcnxt_o, BHT_ON ? 32'h3C : 32'h44);
    chk("t2_pred2", 32'(pred_taken_o), 32'(BHT_ON));
    tick();
    stall_i = 1'b0;
    repeat (3) tick();

    // 3: saturation on index 0 (counter starts at 11)
    stall_i = 1'b1;
    jump(32'h40, 1'b1);
    upd(32'h40, 1'b1, 4);
    at_neg(); chk("t3_sat11", 32'(pred_taken_o), 32'(BHT_ON)); tick();
    upd(32'h40, 1'b0, 1);
    at_neg(); chk("t3_c10", 32'(pred_taken_o), 32'(BHT_ON)); tick();
    upd(32'h40, 1'b0, 3);
    at_neg(); chk("t3_c00", 32'(pred_taken_o), 32'd0); tick();
    upd(32'h40, 1'b0, 1);
    at_neg(); chk("t3_sat00", 32'(pred_taken_o), 32'd0); tick();
    upd(32'h40, 1'b1, 1);
    at_neg(); chk("t3_c01", 32'(pred_taken_o), 32'd0); tick();
    upd(32'h40, 1'b1, 1);
    at_neg();
    chk("t3_c10b", 32'(pred_taken_o), 32'(BHT_ON));
    chk("t3_nxt", pcnxt_o, BHT_ON ? 32'h3C : 32'h44);
    tick();

    // 4: stall hold at 0x20, then stall+redirect
    jump(32'h20, 1'b1);
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("t4_hold", pc_o, 32'h20);
      tick();
    end
    redirect_i = 1'b1;
    redirect_pc_i = 32'h100;
    at_neg();
    chk("t4_flush", 32'(flush_o), 32'd1);
    chk("t4_pc_pre", pc_o, 32'h20);
    tick();
    redirect_i = 1'b0;
    stall_i = 1'b0;
    at_neg();
    chk("t4_pc_redir", pc_o, 32'h100);
    chk("t4_flush0", 32'(flush_o), 32'd0);
    tick();

    // 5: same-cycle update and lookup on index 3
    jump(32'h4C, 1'b1);
    upd_valid_i = 1'b1;
    upd_pc_i = 32'h4C;
    upd_taken_i = 1'b1;
    at_neg();
    chk("t5_pred_old", 32'(pred_taken_o), 32'd0);
    chk("t5_nxt_old", pcnxt_o, 32'h50);
    tick();
    upd_valid_i = 1'b0;
    at_neg();
    chk("t5_pred_new", 32'(pred_taken_o), 32'(BHT_ON));
    chk("t5_nxt_new", pcnxt_o, BHT_ON ? 32'h48 : 32'h50);
    tick();

    // 6: asynchronous mid-run reset clears PC and counters
    jump(32'h80, 1'b1);
    at_neg();
    chk("t6_pc_pre", pc_o, 32'h80);
    #2 rst_i = 1'b0;
    #1;
    chk("t6_pc_async", pc_o, RESET_PC);
    chk("t6_addr_async", imem_addr_o, RESET_PC);
    tick();
    rst_i = 1'b1;
    jump(32'h40, 1'b1);
    at_neg();
    chk("t6_c0_reset", 32'(pred_taken_o), 32'd0);
    chk("t6_c0_nxt", pcnxt_o, 32'h44);
    tick();
    jump(32'h4C, 1'b1);
    at_neg();
    chk("t6_c3_reset", 32'(pred_taken_o), 32'd0);
    chk("t6_c3_nxt", pcnxt_o, 32'h50);
    tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
